// File: rtl/lcd_show_char.sv
// Streams one 8x16 glyph to the LCD byte writer: CASET/RASET/RAMWR window header
// followed by 128 RGB565 pixels expanded from a combinational font ROM.
module lcd_show_char #(
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        wr_done,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_q,
  output logic [8:0]  show_char_data,
  output logic        en_write_show_char,
  output logic        show_char_done,
  output logic        busy
);

  localparam logic [8:0] LAST_IDX = 9'd266;
  localparam logic [8:0] PIX_BASE = 9'd11;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [8:0] idx, idx_nxt;
  logic       latch;
  logic [6:0] ascii_lat;
  logic [8:0] xs_lat, ys_lat;
  logic [8:0] xe, ye;

  function automatic logic [3:0] font_row(input logic [8:0] i);
    return (i < PIX_BASE) ? 4'd0 : 4'((i - PIX_BASE) >> 4);
  endfunction

  function automatic logic [8:0] coord_hi(input logic [8:0] v);
    return {1'b1, 7'd0, v[8]};
  endfunction

  function automatic logic [8:0] coord_lo(input logic [8:0] v);
    return {1'b1, v[7:0]};
  endfunction

  // p_lo is the low nibble of (idx - 11): bit 0 selects the colour byte, [3:1] the column.
  function automatic logic [8:0] pixel_byte(input logic [3:0] p_lo, input logic [7:0] row_bits);
    logic [2:0]  col;
    logic [15:0] colour;
    col    = p_lo[3:1];
    colour = row_bits[3'd7 - col] ? FG_COLOR : BG_COLOR;
    return {1'b1, p_lo[0] ? colour[7:0] : colour[15:8]};
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (show_char_flag) begin
          latch     = 1'b1;
          idx_nxt   = 9'd0;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (wr_done) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 9'd1;
            state_nxt = LOAD;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control stage: state, byte index and the font address for the byte about to be loaded.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      idx       <= 9'd0;
      font_addr <= 11'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state_nxt != IDLE) begin
        font_addr <= {(latch ? ascii_num : ascii_lat), font_row(idx_nxt)};
      end
    end
  end

  // Glyph parameters captured once at start; later input changes are ignored.
  always_ff @(posedge sys_clk) begin
    if (latch) begin
      ascii_lat <= ascii_num;
      xs_lat    <= start_x;
      ys_lat    <= start_y;
    end
  end

  assign xe = xs_lat + 9'd7;
  assign ye = ys_lat + 9'd15;

  always_comb begin
    show_char_data = 9'h000;
    if (state != IDLE) begin
      case (idx)
        9'd0:    show_char_data = 9'h02A;
        9'd1:    show_char_data = coord_hi(xs_lat);
        9'd2:    show_char_data = coord_lo(xs_lat);
        9'd3:    show_char_data = coord_hi(xe);
        9'd4:    show_char_data = coord_lo(xe);
        9'd5:    show_char_data = 9'h02B;
        9'd6:    show_char_data = coord_hi(ys_lat);
        9'd7:    show_char_data = coord_lo(ys_lat);
        9'd8:    show_char_data = coord_hi(ye);
        9'd9:    show_char_data = coord_lo(ye);
        9'd10:   show_char_data = 9'h02C;
        default: show_char_data = pixel_byte(4'(idx - PIX_BASE), font_q);
      endcase
    end
  end

  assign en_write_show_char = (state == LOAD);
  assign show_char_done     = (state == DONE);
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_lcd_show_char.sv
// Bench for lcd_show_char: table of header vectors plus random glyphs, each whole byte
// stream compared against a font/coordinate model built from plain arithmetic.
module tb_lcd_show_char;

  localparam logic [15:0] FG = 16'hA5C3;
  localparam logic [15:0] BG = 16'h3C5A;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        show_char_flag = 1'b0;
  logic [6:0]  ascii_num = '0;
  logic [8:0]  start_x = '0;
  logic [8:0]  start_y = '0;
  logic        wr_done = 1'b0;
  logic [10:0] font_addr;
  logic [7:0]  font_q;
  logic [8:0]  show_char_data;
  logic        en_write_show_char;
  logic        show_char_done;
  logic        busy;

  logic [7:0] font_mem [0:2047];
  assign font_q = font_mem[font_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  typedef struct packed {
    logic [6:0]         ascii;
    logic [8:0]         xs;
    logic [8:0]         ys;
    logic [3:0]         lat;
    logic [0:10][8:0]   hdr;
  } vec_t;

  vec_t vecs [0:4];

  lcd_show_char #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .show_char_flag     (show_char_flag),
    .ascii_num          (ascii_num),
    .start_x            (start_x),
    .start_y            (start_y),
    .wr_done            (wr_done),
    .font_addr          (font_addr),
    .font_q             (font_q),
    .show_char_data     (show_char_data),
    .en_write_show_char (en_write_show_char),
    .show_char_done     (show_char_done),
    .busy               (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] a, input logic [8:0] xs, input logic [8:0] ys,
                              input logic [3:0] lat, input logic [0:10][8:0] hdr);
    vec_t v;
    v.ascii = a; v.xs = xs; v.ys = ys; v.lat = lat; v.hdr = hdr;
    return v;
  endfunction

  // Reference stream: window header from modular coordinate sums, then row-major pixels.
  function automatic void build_exp(input logic [6:0] a, input int xs, input int ys);
    int xe, ye, b;
    logic [15:0] col;
    xe = (xs + 7) % 512;
    ye = (ys + 15) % 512;
    exp_q.delete();
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'(256 + xs / 256));
    exp_q.push_back(9'(256 + xs % 256));
    exp_q.push_back(9'(256 + xe / 256));
    exp_q.push_back(9'(256 + xe % 256));
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'(256 + ys / 256));
    exp_q.push_back(9'(256 + ys % 256));
    exp_q.push_back(9'(256 + ye / 256));
    exp_q.push_back(9'(256 + ye % 256));
    exp_q.push_back(9'h02C);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        b = (int'(font_mem[int'(a) * 16 + r]) >> (7 - c)) & 1;
        col = (b == 1) ? FG : BG;
        exp_q.push_back(9'(256 + int'(col) / 256));
        exp_q.push_back(9'(256 + int'(col) % 256));
      end
    end
  endfunction

  task automatic run_glyph(input logic [6:0] a, input logic [8:0] xs, input logic [8:0] ys,
                           input int lat, input bit inject_flag, input bit spurious,
                           input int reset_at, input bit has_hdr,
                           input logic [0:10][8:0] hdr, input string tag);
    int nb = 0, startc = 0, last_m = -100, t_err = 0, s_err = 0;
    int done_cnt = 0, done_err = 0, busy_err = 0, wcnt = 0, budget, first;
    bit pending = 0, finished = 0, aborted = 0;
    logic [8:0] sdata = '0;
    build_exp(a, int'(xs), int'(ys));
    got_q.delete();
    if (spurious) begin
      @(negedge sys_clk);
      wr_done = 1'b1;
    end
    @(negedge sys_clk);
    wr_done = 1'b0;
    ascii_num = a; start_x = xs; start_y = ys;
    show_char_flag = 1'b1;
    startc = cyc;
    budget = 267 * (lat + 2) + 40;
    for (int k = 0; k < budget && !finished; k++) begin
      @(negedge sys_clk);
      show_char_flag = 1'b0;
      wr_done = 1'b0;
      ascii_num = 7'($urandom); start_x = 9'($urandom); start_y = 9'($urandom);
      if (reset_at > 0 && nb == reset_at && pending) begin
        sys_rst_n = 1'b0;
        #1;
        chk({tag, "_rst_en"}, int'(en_write_show_char), 0);
        chk({tag, "_rst_data"}, int'(show_char_data), 0);
        chk({tag, "_rst_faddr"}, int'(font_addr), 0);
        chk({tag, "_rst_done"}, int'(show_char_done), 0);
        chk({tag, "_rst_busy"}, int'(busy), 0);
        aborted = 1;
        finished = 1;
      end else begin
        if (en_write_show_char) begin
          got_q.push_back(show_char_data);
          if (cyc != ((nb == 0) ? startc + 1 : last_m + 1)) t_err++;
          if (!busy) busy_err++;
          nb++;
          pending = 1;
          wcnt = lat;
          sdata = show_char_data;
          if (spurious && (nb == 6 || nb == 200)) wr_done = 1'b1;
          if (inject_flag && nb == 50) show_char_flag = 1'b1;
        end else if (pending) begin
          if (show_char_data != sdata) s_err++;
          if (!busy) busy_err++;
          wcnt--;
          if (wcnt == 0) begin
            wr_done = 1'b1;
            pending = 0;
            last_m = cyc;
          end
        end
        if (show_char_done) begin
          done_cnt++;
          if (cyc != last_m + 1 || !busy || nb != 267) done_err++;
          if (inject_flag) show_char_flag = 1'b1;
        end
        if (nb >= 267 && !pending && cyc >= last_m + 2 && busy) busy_err++;
        if (nb >= 267 && !pending && cyc >= last_m + 8) finished = 1;
      end
    end
    chk({tag, "_timeout"}, int'(finished), 1);
    if (!aborted) begin
      chk({tag, "_count"}, got_q.size(), 267);
      first = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        if (got_q[i] !== exp_q[i]) begin
          first = i;
          break;
        end
      end
      checks++;
      if (first >= 0) begin
        failures++;
        $display("FAIL %s_seq byte %0d actual=%h required=%h", tag, first, got_q[first], exp_q[first]);
      end
      if (has_hdr) begin
        first = -1;
        for (int i = 0; i < 11; i++) begin
          if (got_q.size() <= i || got_q[i] !== hdr[i]) begin
            first = i;
            break;
          end
        end
        checks++;
        if (first >= 0) begin
          failures++;
          $display("FAIL %s_hdr byte %0d actual=%h required=%h", tag, first,
                   (got_q.size() > first) ? got_q[first] : 9'h000, hdr[first]);
        end
      end
      chk({tag, "_strobe_timing"}, t_err, 0);
      chk({tag, "_data_stable"}, s_err, 0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_timing"}, done_err, 0);
      chk({tag, "_busy"}, busy_err, 0);
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    vecs[0] = mk(7'h41, 9'd0,   9'd0,   4'd3, {9'h02A, 9'h100, 9'h100, 9'h100, 9'h107, 9'h02B,
                                               9'h100, 9'h100, 9'h100, 9'h10F, 9'h02C});
    vecs[1] = mk(7'h30, 9'd200, 9'd300, 4'd2, {9'h02A, 9'h100, 9'h1C8, 9'h100, 9'h1CF, 9'h02B,
                                               9'h101, 9'h12C, 9'h101, 9'h13B, 9'h02C});
    vecs[2] = mk(7'h7F, 9'd508, 9'd500, 4'd1, {9'h02A, 9'h101, 9'h1FC, 9'h100, 9'h103, 9'h02B,
                                               9'h101, 9'h1F4, 9'h100, 9'h103, 9'h02C});
    vecs[3] = mk(7'h00, 9'd255, 9'd497, 4'd4, {9'h02A, 9'h100, 9'h1FF, 9'h101, 9'h106, 9'h02B,
                                               9'h101, 9'h1F1, 9'h100, 9'h100, 9'h02C});
    vecs[4] = mk(7'h5A, 9'd505, 9'd16,  4'd2, {9'h02A, 9'h101, 9'h1F9, 9'h100, 9'h100, 9'h02B,
                                               9'h100, 9'h110, 9'h100, 9'h11F, 9'h02C});

    #12;
    chk("reset_en", int'(en_write_show_char), 0);
    chk("reset_data", int'(show_char_data), 0);
    chk("reset_faddr", int'(font_addr), 0);
    chk("reset_done", int'(show_char_done), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 5; i++) begin
      run_glyph(vecs[i].ascii, vecs[i].xs, vecs[i].ys, int'(vecs[i].lat), 1'b0, 1'b0, 0, 1'b1,
                vecs[i].hdr, $sformatf("vec%0d", i));
    end

    run_glyph(7'h23, 9'd40, 9'd80, 2, 1'b1, 1'b0, 0, 1'b0, '0, "busy_reject");
    run_glyph(7'h52, 9'd17, 9'd33, 1, 1'b0, 1'b1, 0, 1'b0, '0, "spurious");

    run_glyph(7'h66, 9'd100, 9'd120, 3, 1'b0, 1'b0, 100, 1'b0, '0, "midreset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (en_write_show_char || busy) cnt++;
    end
    chk("post_reset_quiet", cnt, 0);
    run_glyph(7'h66, 9'd100, 9'd120, 3, 1'b0, 1'b0, 0, 1'b0, '0, "after_reset");

    for (int i = 0; i < 4; i++) begin
      run_glyph(7'($urandom), 9'($urandom), 9'($urandom), int'($urandom_range(1, 4)),
                1'b0, 1'b0, 0, 1'b0, '0, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_show_char.md
# lcd_show_char

Renders one 8x16 ASCII glyph into the LCD at a given pixel position. It sends the ST7789-style window commands and then 128 RGB565 pixels as a byte stream to the SPI byte writer (`lcd_write`), one byte per `wr_done` handshake. It sits beside `lcd_show_pic` as a second content source behind the `control` mux. It owns its own font-ROM address port; the font ROM is combinational.

## Interface
- `FG_COLOR`, 16'hFFFF: RGB565 colour for font bits equal to 1.
- `BG_COLOR`, 16'h0000: RGB565 colour for font bits equal to 0.

- `sys_clk`  in  1: single clock for the whole block.
- `sys_rst_n`  in  1: asynchronous active-low reset.
- `show_char_flag`  in  1: start pulse; sampled only in IDLE.
- `ascii_num`  in  7: glyph code; latched at start.
- `start_x`  in  9: top-left column; latched at start.
- `start_y`  in  9: top-left row; latched at start.
- `wr_done`  in  1: one-cycle pulse from `lcd_write` marking the end of the current byte.
- `font_addr`  out  11: font ROM address, `{ascii_code, row[3:0]}`.
- `font_q`  in  8: glyph row byte; bit 7 is the leftmost pixel. Valid in the same cycle as `font_addr`.
- `show_char_data`  out  9: byte to send; bit 8 is DC (0 = command, 1 = data), bits [7:0] are the payload.
- `en_write_show_char`  out  1: one-cycle write strobe.
- `show_char_done`  out  1: one-cycle completion pulse.
- `busy`  out  1: high while a glyph is in progress.

## Operation
- **States:** IDLE, LOAD, WAIT, DONE.
- **IDLE:** when `show_char_flag` is 1:
  - latch `ascii_num`, `start_x` and `start_y`;
  - clear the byte index `idx` (9 bits);
  - set `busy`;
  - go to LOAD.
- **LOAD:** drive `show_char_data` from `idx`, pulse `en_write_show_char` for one cycle, go to WAIT.
- **WAIT:** hold `show_char_data` stable until `wr_done`.
  - On `wr_done` with `idx` = 266: go to DONE.
  - On `wr_done` otherwise: increment `idx` and go to LOAD.
- **DONE:** pulse `show_char_done` for one cycle, clear `busy`, go to IDLE.
- **Coordinate arithmetic:** `xe = xs + 7` and `ye = ys + 15`, both computed in 9 bits. The sum truncates mod 512 with no saturation. Each coordinate is sent as the 16-bit value `{7'b0, v}`.
- **Byte map, header (`idx` 0–10):**
  - `idx` 0: 0x02A (CASET command).
  - `idx` 1: 0x100 | `xs[8]`.
  - `idx` 2: 0x100 | `xs[7:0]`.
  - `idx` 3: 0x100 | `xe[8]`.
  - `idx` 4: 0x100 | `xe[7:0]`.
  - `idx` 5: 0x02B (RASET command).
  - `idx` 6–9: the same four-byte pattern using `ys` and `ye`.
  - `idx` 10: 0x02C (RAMWR command).
- **Byte map, pixels (`idx` 11–266):**
  - `p = idx - 11`, `pix = p >> 1`, `row = pix[6:3]`, `col = pix[2:0]`.
  - `bit = font_q[7 - col]` with `font_addr = {ascii_latched, row}`.
  - `colour = bit ? FG_COLOR : BG_COLOR`.
  - Even `p` sends 0x100 | `colour[15:8]`; odd `p` sends 0x100 | `colour[7:0]`.
- **Transaction size:** 267 bytes per glyph. Pixels are row-major, top row first, left to right.
- **Boundary rules:**
  - `show_char_flag` outside IDLE, including the DONE cycle, is ignored. Nothing is queued.
  - `wr_done` outside WAIT is ignored.
  - Inputs changing after the start cycle have no effect.
  - Reset mid-glyph returns all outputs to their reset values immediately and abandons the glyph. No further `en_write_show_char` is issued.

## Timing
- **Reset values:**
  - `show_char_data` = 9'h000, `font_addr` = 0.
  - `en_write_show_char` = 0, `show_char_done` = 0, `busy` = 0.
  - State = IDLE.
- **Start:** flag sampled high at cycle N. `busy` is high from N+1. The first `en_write_show_char` pulse, with data 0x02A, is at cycle N+1.
- **Between bytes:** `wr_done` at cycle M produces the next strobe at M+1. Throughput is one byte per (writer latency + 1) cycles.
- **Data stability:** `show_char_data` is valid on the strobe cycle and held until the cycle after the matching `wr_done`.
- **Font lookup:** `font_addr` is registered and updated no later than the strobe cycle of each pixel byte. `font_q` is consumed combinationally when forming the data.
- **Completion:**
  - Last `wr_done` at cycle M → `show_char_done` = 1 at M+1, while `busy` is still 1 in that cycle.
  - `busy` = 0 at M+2.
  - A new flag is first accepted at M+2.

## Test plan
- **Basic glyph:** `ascii_num` = 0x41, `xs` = 0, `ys` = 0, writer model returns `wr_done` 3 cycles after each strobe.
  - Header must be 0x02A, 0x100, 0x100, 0x100, 0x107, 0x02B, 0x100, 0x100, 0x100, 0x10F, 0x02C.
  - Then exactly 256 data bytes matching the font model with FG/BG expansion, then one `show_char_done` pulse.
- **High coordinates:** `xs` = 200, `ys` = 300 → CASET bytes 0x100, 0x1C8, 0x100, 0x1CF; RASET bytes 0x101, 0x12C, 0x101, 0x13B.
- **Wrap-around:** `xs` = 508, `ys` = 500.
  - `xe` bytes must be 0x100, 0x103.
  - `ye` bytes must be 0x100, 0x003 | 0x100 = 0x103 (500 + 15 = 515 mod 512 = 3).
- **Busy rejection and strobe timing:**
  - Pulse `show_char_flag` again mid-glyph and on the DONE cycle → exactly 267 strobes total, one done pulse.
  - Each strobe must fall exactly 1 cycle after the previous `wr_done`.
- **Spurious handshake:** inject `wr_done` in the LOAD cycle and while IDLE → byte count and sequence unchanged.
- **Reset mid-glyph:** assert `sys_rst_n` low after byte 100.
  - All outputs go to reset values asynchronously, with no strobe after release.
  - A new flag then produces a full 267-byte glyph starting at 0x02A.
